fmap_stream_out: RTL and testbench
==================================

// Module: fmap_stream_out
// PURPOSE
// - Sequential reader for the packed feature-map bus produced by conv2d: captures one flat
//   out_channels x output_rows x output_cols map, then streams it one element per beat over valid/ready.
// - Sits between a conv2d instance and the next streaming stage (pooling, activation, DMA writer).
// - Decouples the wide combinational conv2d result from narrow downstream logic.
// PARAMETERS
// - channels    default 1   feature-map channels (conv2d out_channels)
// - rows        default 27  map rows (conv2d output_rows)
// - cols        default 27  map cols (conv2d output_cols)
// - data_size   default 8   bits per element, signed two's complement
// PORTS
// - clk             in   1                             rising-edge clock
// - rst             in   1                             synchronous reset, active-high
// - in_map          in   channels*rows*cols*data_size  packed map; element (c,r,k) at bit ((c*rows+r)*cols+k)*data_size, LSB first
// - in_valid        in   1                             in_map valid
// - in_ready        out  1                             block can capture a map
// - out_data        out  data_size                     current element (signed)
// - out_valid       out  1                             out_data valid
// - out_ready       in   1                             downstream accepts
// - out_ch          out  $clog2(channels)  (min 1)     channel index of out_data
// - out_row         out  $clog2(rows)      (min 1)     row index
// - out_col         out  $clog2(cols)      (min 1)     col index
// - out_last_row    out  1                             out_col == cols-1
// - out_last_frame  out  1                             final element of the map
// BEHAVIOUR
// - Single clock, synchronous active-high reset. On rst=1: state=IDLE; in_ready=1; out_valid=0;
//   out_data=0; out_ch/out_row/out_col=0; out_last_row=0; out_last_frame=0; capture register cleared.
// - FSM states:
//   - IDLE: in_ready=1, out_valid=0.
//     in_valid&&in_ready -> register in_map, zero counters, go to STREAM.
//   - STREAM: in_ready=0, out_valid=1. in_valid is ignored.
// - Latency: element (0,0,0) presented the cycle after capture.
// - Beat: out_valid&&out_ready advances the counters: col fastest, then row, then channel
//   (col wraps cols-1->0 and increments row; row wraps rows-1->0 and increments ch).
// - out_valid=1 && out_ready=0: hold out_data and all indices/flags stable.
// - out_data, indices and flags are registered; they are a function of the counters and the captured map.
// - Last beat accepted (ch=channels-1, row=rows-1, col=cols-1) -> IDLE; in_ready=1 next cycle.
//   Map rate is therefore channels*rows*cols+1 cycles per map, minimum.
// - Degenerate sizes: rows=1 or cols=1 makes that counter stay 0. If channels=rows=cols=1,
//   out_last_row=out_last_frame=1 on the single beat.
// - Reset mid-stream: frame is dropped, state returns to IDLE; no partial completion.
// - in_map changing while in STREAM has no effect; the captured copy is used.
// - No arithmetic on data; element bits are passed through unchanged unless the macro below is defined.
// CONFIGURATION
// - FMAP_STREAM_RELU_EN defined: out_data = (element[data_size-1] ? 0 : element), i.e. a fused ReLU
//   applied at the output mux, still registered, no added latency.
// - FMAP_STREAM_RELU_EN undefined: out_data = element bits verbatim (negative values pass through).
// TESTING  (channels=2, rows=2, cols=3, data_size=8 unless noted)
// - Reset: assert rst 2 cycles mid-stream -> next cycle out_valid=0, in_ready=1, all outputs 0.
// - Order: in_map elements = 0x01..0x0C (index+1), out_ready=1 -> 12 beats on consecutive cycles,
//   out_data 0x01..0x0C, (ch,row,col) (0,0,0)..(1,1,2); out_last_row on beats 3,6,9,12;
//   out_last_frame only on beat 12; in_ready=1 cycle after beat 12.
// - Backpressure: out_ready low for 5 cycles at beat 4 -> out_data=0x04 with (0,1,0) held stable,
//   no beat lost or duplicated; total 12 beats.
// - Ignore: in_valid held high with a different map during STREAM -> stream unchanged;
//   second map captured only after return to IDLE.
// - ReLU: element 0 = 0x80 (-128), element 1 = 0x7F -> with FMAP_STREAM_RELU_EN: 0x00, 0x7F;
//   without: 0x80, 0x7F.
// - Degenerate: channels=rows=cols=1, element 0xA5 -> one beat, out_last_row=out_last_frame=1,
//   then IDLE.

Source files
------------

// File: rtl/fmap_stream_out.sv
// Captures one packed channels x rows x cols feature map and streams it one element per beat.
// Optional macro FMAP_STREAM_RELU_EN fuses a ReLU into the registered output mux.
module fmap_stream_out #(
  parameter  int channels  = 1,
  parameter  int rows      = 27,
  parameter  int cols      = 27,
  parameter  int data_size = 8,
  localparam int CW        = (channels > 1) ? $clog2(channels) : 1,
  localparam int RW        = (rows > 1) ? $clog2(rows) : 1,
  localparam int KW        = (cols > 1) ? $clog2(cols) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [channels*rows*cols*data_size-1:0]    in_map,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  output logic signed [data_size-1:0]                out_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [CW-1:0]                              out_ch,
  output logic [RW-1:0]                              out_row,
  output logic [KW-1:0]                              out_col,
  output logic                                       out_last_row,
  output logic                                       out_last_frame
);

  localparam int N     = channels * rows * cols;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int DEPTH = 1 << IW;

  localparam logic [CW-1:0] CH_MAX  = CW'(channels - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(rows - 1);
  localparam logic [KW-1:0] COL_MAX = KW'(cols - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [data_size-1:0] r_map      [DEPTH];
  logic [data_size-1:0] w_in_elems [DEPTH];

  logic signed [data_size-1:0] r_data;
  logic [CW-1:0]               r_ch;
  logic [RW-1:0]               r_row;
  logic [KW-1:0]               r_col;
  logic                        r_last_row;
  logic                        r_last_frame;

  logic                 w_capture;
  logic                 w_beat;
  logic                 w_end;
  logic                 w_update;
  logic [CW-1:0]        w_nxt_ch;
  logic [RW-1:0]        w_nxt_row;
  logic [KW-1:0]        w_nxt_col;
  logic [IW-1:0]        w_idx;
  logic [data_size-1:0] w_elem;
  logic [data_size-1:0] w_nxt_data;
  logic                 w_nxt_last_row;
  logic                 w_nxt_last_frame;

  // Power-of-two unpacked view so the element index never outgrows its array.
  for (genvar g = 0; g < DEPTH; g++) begin : g_unpack
    if (g < N) begin : g_elem
      assign w_in_elems[g] = in_map[g*data_size +: data_size];
    end else begin : g_pad
      assign w_in_elems[g] = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready && w_end) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_capture = (r_state == IDLE) && in_valid;
    w_beat    = (r_state == STREAM) && out_ready;
    w_end     = (r_ch == CH_MAX) && (r_row == ROW_MAX) && (r_col == COL_MAX);
    w_update  = w_capture || w_beat;
    w_nxt_ch  = r_ch;
    w_nxt_row = r_row;
    w_nxt_col = r_col;
    if (w_capture || (w_beat && w_end)) begin
      w_nxt_ch  = '0;
      w_nxt_row = '0;
      w_nxt_col = '0;
    end else if (w_beat) begin
      if (r_col == COL_MAX) begin
        w_nxt_col = '0;
        if (r_row == ROW_MAX) begin
          w_nxt_row = '0;
          w_nxt_ch  = r_ch + CW'(1);
        end else begin
          w_nxt_row = r_row + RW'(1);
        end
      end else begin
        w_nxt_col = r_col + KW'(1);
      end
    end

    w_idx  = IW'((int'(w_nxt_ch) * rows + int'(w_nxt_row)) * cols + int'(w_nxt_col));
    w_elem = w_capture ? w_in_elems[0] : r_map[w_idx];
`ifdef FMAP_STREAM_RELU_EN
    w_nxt_data = w_elem[data_size-1] ? '0 : w_elem;
`else
    w_nxt_data = w_elem;
`endif

    // Finishing the frame parks the outputs at their reset values.
    w_nxt_last_row   = (w_nxt_col == COL_MAX);
    w_nxt_last_frame = w_nxt_last_row && (w_nxt_row == ROW_MAX) && (w_nxt_ch == CH_MAX);
    if (w_beat && w_end) begin
      w_nxt_data       = '0;
      w_nxt_last_row   = 1'b0;
      w_nxt_last_frame = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the capture buffer is reset too, so a dropped frame leaves no stale data behind.
    if (rst) begin
      r_map        <= '{default: '0};
      r_data       <= '0;
      r_ch         <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_last_row   <= 1'b0;
      r_last_frame <= 1'b0;
    end else begin
      if (w_capture) r_map <= w_in_elems;
      if (w_update) begin
        r_data       <= w_nxt_data;
        r_ch         <= w_nxt_ch;
        r_row        <= w_nxt_row;
        r_col        <= w_nxt_col;
        r_last_row   <= w_nxt_last_row;
        r_last_frame <= w_nxt_last_frame;
      end
    end
  end

  assign out_data       = r_data;
  assign out_ch         = r_ch;
  assign out_row        = r_row;
  assign out_col        = r_col;
  assign out_last_row   = r_last_row;
  assign out_last_frame = r_last_frame;

endmodule

// File: tb/tb_fmap_stream_out.sv
// Directed bench for fmap_stream_out: a 2x2x3 map instance and a 1x1x1 degenerate instance.
// Expected ReLU results follow FMAP_STREAM_RELU_EN as defined for the build.
module tb_fmap_stream_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [95:0]       in_map;
  logic              in_valid, in_ready;
  logic signed [7:0] out_data;
  logic              out_valid, out_ready;
  logic [0:0]        out_ch, out_row;
  logic [1:0]        out_col;
  logic              out_last_row, out_last_frame;

  logic [7:0]        d_in_map;
  logic              d_in_valid, d_in_ready;
  logic signed [7:0] d_out_data;
  logic              d_out_valid, d_out_ready;
  logic [0:0]        d_out_ch, d_out_row, d_out_col;
  logic              d_out_last_row, d_out_last_frame;

  int checks = 0;
  int errors = 0;

  // Beat-order tables for channels=2, rows=2, cols=3 (col fastest).
  int exp_ch  [12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
  int exp_row [12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
  int exp_col [12] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};

  fmap_stream_out #(.channels(2), .rows(2), .cols(3), .data_size(8)) dut (
    .clk(clk), .rst(rst), .in_map(in_map), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_row(out_row), .out_col(out_col),
    .out_last_row(out_last_row), .out_last_frame(out_last_frame)
  );

  fmap_stream_out #(.channels(1), .rows(1), .cols(1), .data_size(8)) dut1 (
    .clk(clk), .rst(rst), .in_map(d_in_map), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .out_data(d_out_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_ch(d_out_ch), .out_row(d_out_row), .out_col(d_out_col),
    .out_last_row(d_out_last_row), .out_last_frame(d_out_last_frame)
  );

  function automatic logic [95:0] pack_map(input logic [7:0] v [12]);
    logic [95:0] m = '0;
    for (int i = 11; i >= 0; i--) m = {m[87:0], v[i]};
    return m;
  endfunction

  function automatic logic [7:0] exp_out(input logic [7:0] e);
`ifdef FMAP_STREAM_RELU_EN
    return e[7] ? 8'h00 : e;
`else
    return e;
`endif
  endfunction

  // Leaves the bench at the falling edge where the first element is presented.
  task automatic capture(input logic [95:0] m);
    @(negedge clk);
    in_map   = m;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v [12];
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_map = '0;
    d_in_valid = 1'b0; d_out_ready = 1'b1; d_in_map = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'sh00 || out_ch !== 1'b0 ||
        out_row !== 1'b0 || out_col !== 2'd0 || out_last_row !== 1'b0 || out_last_frame !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: valid=%b ready=%b data=%h idx=%0d,%0d,%0d flags=%b%b, required valid=0 ready=1 all zero",
               out_valid, in_ready, out_data, out_ch, out_row, out_col, out_last_row, out_last_frame);
    end
    checks++;
    if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0 || d_out_data !== 8'sh00) begin
      errors++;
      $display("FAIL reset_init_degen: ready=%b valid=%b data=%h, required 1 0 00", d_in_ready, d_out_valid, d_out_data);
    end

    for (int i = 0; i < 12; i++) v[i] = 8'(i + 1);
    out_ready = 1'b1;
    capture(pack_map(v));
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'sh04 || out_row !== 1'b1) begin
      errors++;
      $display("FAIL reset_midstream_setup: valid=%b data=%h row=%0d, required 1 04 1", out_valid, out_data, out_row);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'sh00 || out_ch !== 1'b0 ||
        out_row !== 1'b0 || out_col !== 2'd0 || out_last_row !== 1'b0 || out_last_frame !== 1'b0) begin
      errors++;
      $display("FAIL reset_midstream: valid=%b ready=%b data=%h idx=%0d,%0d,%0d flags=%b%b, required valid=0 ready=1 all zero",
               out_valid, in_ready, out_data, out_ch, out_row, out_col, out_last_row, out_last_frame);
    end
  endtask

  task automatic test_order();
    logic [7:0] v [12];
    for (int i = 0; i < 12; i++) v[i] = 8'(i + 1);
    out_ready = 1'b1;
    capture(pack_map(v));
    for (int b = 0; b < 12; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(b + 1) || in_ready !== 1'b0 ||
          out_ch !== 1'(exp_ch[b]) || out_row !== 1'(exp_row[b]) || out_col !== 2'(exp_col[b]) ||
          out_last_row !== ((b % 3) == 2) || out_last_frame !== (b == 11)) begin
        errors++;
        $display("FAIL order_beat%0d: valid=%b data=%h idx=%0d,%0d,%0d lr=%b lf=%b, required 1 %h %0d,%0d,%0d lr=%b lf=%b",
                 b + 1, out_valid, out_data, out_ch, out_row, out_col, out_last_row, out_last_frame,
                 8'(b + 1), exp_ch[b], exp_row[b], exp_col[b], (b % 3) == 2, b == 11);
      end
      @(negedge clk);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_return_idle: ready=%b valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] v [12];
    int b = 0;
    int hold = 0;
    for (int i = 0; i < 12; i++) v[i] = 8'(i + 1);
    out_ready = 1'b1;
    capture(pack_map(v));
    for (int cyc = 0; cyc < 60 && b < 12; cyc++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(b + 1) || out_ch !== 1'(exp_ch[b]) ||
          out_row !== 1'(exp_row[b]) || out_col !== 2'(exp_col[b])) begin
        errors++;
        $display("FAIL backpressure_beat%0d cyc%0d: valid=%b data=%h idx=%0d,%0d,%0d, required 1 %h %0d,%0d,%0d",
                 b + 1, cyc, out_valid, out_data, out_ch, out_row, out_col,
                 8'(b + 1), exp_ch[b], exp_row[b], exp_col[b]);
      end
      if (b == 3 && hold < 5) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_ready) b++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (b != 12 || hold != 5 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_total: beats=%0d holds=%0d ready=%b valid=%b, required 12 5 1 0",
               b, hold, in_ready, out_valid);
    end
  endtask

  task automatic test_ignore();
    logic [7:0] va [12];
    logic [7:0] vb [12];
    for (int i = 0; i < 12; i++) begin
      va[i] = 8'(i + 1);
      vb[i] = 8'(8'hF1 + i);
    end
    out_ready = 1'b1;
    capture(pack_map(va));
    in_map   = pack_map(vb);
    in_valid = 1'b1;
    for (int b = 0; b < 12; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(b + 1)) begin
        errors++;
        $display("FAIL ignore_beat%0d: valid=%b data=%h, required 1 %h", b + 1, out_valid, out_data, 8'(b + 1));
      end
      @(negedge clk);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle_gap: ready=%b valid=%b, required 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int b = 0; b < 12; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_out(vb[b])) begin
        errors++;
        $display("FAIL ignore_second_map_beat%0d: valid=%b data=%h, required 1 %h",
                 b + 1, out_valid, out_data, exp_out(vb[b]));
      end
      @(negedge clk);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ignore_second_map_end: ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_relu();
    logic [7:0] v [12];
    for (int i = 0; i < 12; i++) v[i] = 8'(i + 1);
    v[0] = 8'h80;
    v[1] = 8'h7F;
    out_ready = 1'b1;
    capture(pack_map(v));
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_out(8'h80)) begin
      errors++;
      $display("FAIL relu_elem0: valid=%b data=%h, required 1 %h", out_valid, out_data, exp_out(8'h80));
    end
    @(negedge clk);
    checks++;
    if (out_data !== 8'sh7F) begin
      errors++;
      $display("FAIL relu_elem1: data=%h, required 7f", out_data);
    end
    @(negedge clk);
    checks++;
    if (out_data !== 8'sh03) begin
      errors++;
      $display("FAIL relu_elem2: data=%h, required 03", out_data);
    end
    for (int i = 0; i < 20 && in_ready !== 1'b1; i++) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL relu_drain: ready=%b, required 1 within 20 cycles", in_ready);
    end
  endtask

  task automatic test_degenerate();
    d_out_ready = 1'b1;
    @(negedge clk);
    d_in_map   = 8'hA5;
    d_in_valid = 1'b1;
    @(negedge clk);
    d_in_valid = 1'b0;
    checks++;
    if (d_out_valid !== 1'b1 || d_out_data !== exp_out(8'hA5) || d_in_ready !== 1'b0 ||
        d_out_ch !== 1'b0 || d_out_row !== 1'b0 || d_out_col !== 1'b0 ||
        d_out_last_row !== 1'b1 || d_out_last_frame !== 1'b1) begin
      errors++;
      $display("FAIL degenerate_beat: valid=%b data=%h ready=%b idx=%0d,%0d,%0d lr=%b lf=%b, required 1 %h 0 0,0,0 lr=1 lf=1",
               d_out_valid, d_out_data, d_in_ready, d_out_ch, d_out_row, d_out_col,
               d_out_last_row, d_out_last_frame, exp_out(8'hA5));
    end
    @(negedge clk);
    checks++;
    if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL degenerate_idle: valid=%b ready=%b, required 0 1", d_out_valid, d_in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_backpressure();
    test_ignore();
    test_relu();
    test_degenerate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
